// File: rtl/hazard_stall_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit_if
// Bundle of pipeline-side signals exchanged with the hazard/stall controller.
//
// Signals (direction seen from the controller, i.e. the slave modport):
//   in : IF_ID_Rs/Rt [3:0], IF_ID_uses_Rs/Rt, IF_ID_MemWrite, IF_ID_halt,
//        ID_EX_MemRead, ID_EX_Rd [3:0], branch_taken, i_mem_busy, d_mem_busy
//   out: pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
//        back_write, halted, stall_cycles [CNT_W-1:0], flush_count [CNT_W-1:0]
//
// master : pipeline datapath side (drives hazard inputs, receives controls)
// slave  : the controller itself
// -----------------------------------------------------------------------------
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  // Decode / execute stage status
  logic [3:0]       IF_ID_Rs;
  logic [3:0]       IF_ID_Rt;
  logic             IF_ID_uses_Rs;
  logic             IF_ID_uses_Rt;
  logic             IF_ID_MemWrite;
  logic             IF_ID_halt;
  logic             ID_EX_MemRead;
  logic [3:0]       ID_EX_Rd;
  logic             branch_taken;
  logic             i_mem_busy;
  logic             d_mem_busy;

  // Pipeline controls
  logic             pc_write;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_write;
  logic             ID_EX_bubble;
  logic             back_write;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_uses_Rs, IF_ID_uses_Rt, IF_ID_MemWrite,
           IF_ID_halt, ID_EX_MemRead, ID_EX_Rd, branch_taken, i_mem_busy,
           d_mem_busy,
    input  pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
           back_write, halted, stall_cycles, flush_count
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_uses_Rs, IF_ID_uses_Rt, IF_ID_MemWrite,
           IF_ID_halt, ID_EX_MemRead, ID_EX_Rd, branch_taken, i_mem_busy,
           d_mem_busy,
    output pc_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble,
           back_write, halted, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// hazard_stall_unit
// Hazard and stall controller for the 5-stage pipeline. Detects load-use
// dependences that forwarding cannot resolve, applies memory freezes, branch
// redirects and i-miss stalls, sequences the HALT drain, and keeps saturating
// performance counters.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   hz    : hazard_stall_unit_if.slave bundle (hazard inputs, pipeline
//           write enables / flush / bubble, halted, stall_cycles, flush_count)
//
// Parameters:
//   DRAIN_CYCLES : stages between ID and WB completion for the HALT drain (>=1)
//   CNT_W        : performance counter width
// -----------------------------------------------------------------------------
module hazard_stall_unit #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hazard_stall_unit_if.slave    hz
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             halted_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Raw (pre-reset-gating) control values from the output process
  logic pc_write_c, if_id_write_c, if_id_flush_c;
  logic id_ex_write_c, id_ex_bubble_c, back_write_c;
  logic redirect_c;

  logic lu;
  logic rs_hit, rt_hit;
  logic stall_ev, flush_ev;

  // ---------------------------------------------------------------------------
  // Load-use detection. Store data on Rt is forwarded MEM-to-MEM, so a store
  // reading Rt never stalls; register 0 is hard-wired and never a hazard.
  // ---------------------------------------------------------------------------
  assign rs_hit = hz.IF_ID_uses_Rs && (hz.IF_ID_Rs == hz.ID_EX_Rd);
  assign rt_hit = hz.IF_ID_uses_Rt && (hz.IF_ID_Rt == hz.ID_EX_Rd) &&
                  !hz.IF_ID_MemWrite;
  assign lu     = hz.ID_EX_MemRead && (hz.ID_EX_Rd != 4'd0) && (rs_hit || rt_hit);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        // HALT only takes effect when nothing of higher priority is pending
        if (!hz.d_mem_busy && !hz.branch_taken && !lu && hz.IF_ID_halt) begin
          state_d = ST_DRAIN;
          drain_d = DW'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (hz.d_mem_busy) begin
          // frozen: counter holds
          drain_d = drain_q;
        end else if (hz.branch_taken) begin
          // HALT was on the wrong path; squash it
          state_d = ST_RUN;
          drain_d = '0;
        end else begin
          drain_d = drain_q - DW'(1);
          if (drain_q == DW'(1)) begin
            state_d = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        drain_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (combinational from state and inputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write_c     = 1'b0;
    if_id_write_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_write_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    back_write_c   = 1'b0;
    redirect_c     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hz.d_mem_busy) begin
          // freeze: everything stays at 0
          pc_write_c = 1'b0;
        end else if (hz.branch_taken) begin
          redirect_c     = 1'b1;
          pc_write_c     = 1'b1;
          if_id_write_c  = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_write_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          back_write_c   = 1'b1;
        end else if (lu) begin
          // hold IF/ID, inject a bubble into EX
          id_ex_write_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          back_write_c   = 1'b1;
        end else if (hz.IF_ID_halt || hz.i_mem_busy) begin
          // HALT decode and i-miss: stop fetch, NOP into IF/ID, rest advances
          if_id_write_c  = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_write_c  = 1'b1;
          back_write_c   = 1'b1;
        end else begin
          pc_write_c     = 1'b1;
          if_id_write_c  = 1'b1;
          id_ex_write_c  = 1'b1;
          back_write_c   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (hz.d_mem_busy) begin
          pc_write_c = 1'b0;
        end else if (hz.branch_taken) begin
          redirect_c     = 1'b1;
          pc_write_c     = 1'b1;
          if_id_write_c  = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_write_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          back_write_c   = 1'b1;
        end else begin
          if_id_write_c  = 1'b1;
          if_id_flush_c  = 1'b1;
          id_ex_write_c  = 1'b1;
          back_write_c   = 1'b1;
        end
      end
      default: begin
        // HALTED (and any illegal encoding): everything off
        pc_write_c = 1'b0;
      end
    endcase
  end

  // Reset forces all outputs inactive during the reset cycle itself
  assign hz.pc_write     = rst_n & pc_write_c;
  assign hz.IF_ID_write  = rst_n & if_id_write_c;
  assign hz.IF_ID_flush  = rst_n & if_id_flush_c;
  assign hz.ID_EX_write  = rst_n & id_ex_write_c;
  assign hz.ID_EX_bubble = rst_n & id_ex_bubble_c;
  assign hz.back_write   = rst_n & back_write_c;
  assign hz.halted       = rst_n & halted_q;
  assign hz.stall_cycles = rst_n ? stall_q : '0;
  assign hz.flush_count  = rst_n ? flush_q : '0;

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  assign stall_ev = (state_q == ST_RUN) && !pc_write_c;
  assign flush_ev = redirect_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_ev && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush_ev && (flush_q != {CNT_W{1'b1}})) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_unit
// Directed bench for hazard_stall_unit. Expected control vectors are queued
// when a step is driven and popped at the following falling edge.
// Vector order: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write,
//                ID_EX_bubble, back_write, halted}
// -----------------------------------------------------------------------------
module tb_hazard_stall_unit;

  localparam logic [6:0] C_RST    = 7'b0000000;
  localparam logic [6:0] C_NORM   = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_REDIR  = 7'b1111110;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_FLUSH  = 7'b0111010; // HALT decode, DRAIN, i-miss
  localparam logic [6:0] C_HALTED = 7'b0000001;

  logic clk = 1'b0;
  logic rst_n;

  hazard_stall_unit_if #(.CNT_W(16)) hz ();

  hazard_stall_unit #(
    .DRAIN_CYCLES (3),
    .CNT_W        (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];

  task automatic clr_in();
    hz.IF_ID_Rs       = 4'd0;
    hz.IF_ID_Rt       = 4'd0;
    hz.IF_ID_uses_Rs  = 1'b0;
    hz.IF_ID_uses_Rt  = 1'b0;
    hz.IF_ID_MemWrite = 1'b0;
    hz.IF_ID_halt     = 1'b0;
    hz.ID_EX_MemRead  = 1'b0;
    hz.ID_EX_Rd       = 4'd0;
    hz.branch_taken   = 1'b0;
    hz.i_mem_busy     = 1'b0;
    hz.d_mem_busy     = 1'b0;
  endtask

  // One clock step: inputs already driven; expected controls go to the
  // scoreboard, are popped at the falling edge, then the rising edge passes.
  task automatic step(input string tag, input logic [6:0] e);
    logic [6:0] got;
    logic [6:0] exp_v;
    exp_q.push_back(e);
    @(negedge clk);
    got = {hz.pc_write, hz.IF_ID_write, hz.IF_ID_flush, hz.ID_EX_write,
           hz.ID_EX_bubble, hz.back_write, hz.halted};
    exp_v = exp_q.pop_front();
    n_tests++;
    assert (got === exp_v) else begin
      n_fail++;
      $error("FAIL %s: ctl observed %b expected %b", tag, got, exp_v);
    end
    $display("[TB] %s ctl=%b", tag, got);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp_v);
    n_tests++;
    assert (got === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp_v);
    end
    $display("[TB] %s val=%h", tag, got);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    clr_in();
    step(tag, C_RST);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_in();
    @(posedge clk);
    #1;

    // ---- reset state
    do_reset("reset");
    chk("reset_stall", hz.stall_cycles, 16'h0000);
    chk("reset_flush", hz.flush_count, 16'h0000);
    step("idle", C_NORM);

    // ---- load-use on Rs
    hz.ID_EX_MemRead = 1'b1; hz.ID_EX_Rd = 4'd5;
    hz.IF_ID_uses_Rs = 1'b1; hz.IF_ID_Rs = 4'd5;
    step("lu_rs", C_LU);
    hz.ID_EX_MemRead = 1'b0; hz.ID_EX_Rd = 4'd0;   // bubble now in EX
    step("lu_after", C_NORM);
    chk("lu_stall_cnt", hz.stall_cycles, 16'd1);

    // ---- store data on Rt does not stall
    clr_in();
    hz.ID_EX_MemRead = 1'b1; hz.ID_EX_Rd = 4'd5;
    hz.IF_ID_uses_Rt = 1'b1; hz.IF_ID_Rt = 4'd5; hz.IF_ID_MemWrite = 1'b1;
    step("store_rt", C_NORM);
    // same Rt but not a store -> stall
    hz.IF_ID_MemWrite = 1'b0;
    step("lu_rt", C_LU);
    // register 0 never hazards
    clr_in();
    hz.ID_EX_MemRead = 1'b1; hz.ID_EX_Rd = 4'd0;
    hz.IF_ID_uses_Rs = 1'b1; hz.IF_ID_Rs = 4'd0;
    step("r0", C_NORM);
    chk("stall_cnt2", hz.stall_cycles, 16'd2);

    // ---- redirect beats load-use and i-miss
    do_reset("rst_redir");
    hz.ID_EX_MemRead = 1'b1; hz.ID_EX_Rd = 4'd7;
    hz.IF_ID_uses_Rs = 1'b1; hz.IF_ID_Rs = 4'd7;
    hz.i_mem_busy = 1'b1; hz.branch_taken = 1'b1;
    chk("flush_before", hz.flush_count, 16'd0);
    step("redir_prio", C_REDIR);
    chk("flush_after", hz.flush_count, 16'd1);
    chk("redir_nostall", hz.stall_cycles, 16'd0);

    // ---- d_mem_busy dominates for 3 cycles, then the redirect
    do_reset("rst_freeze");
    hz.branch_taken = 1'b1; hz.d_mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step($sformatf("freeze%0d", i), C_FREEZE);
    hz.d_mem_busy = 1'b0;
    step("freeze_redir", C_REDIR);
    chk("freeze_flush", hz.flush_count, 16'd1);
    chk("freeze_stall", hz.stall_cycles, 16'd3);

    // ---- HALT drain: T decode, T+1..T+3 DRAIN, T+4 halted
    do_reset("rst_halt");
    hz.IF_ID_halt = 1'b1;
    step("halt_T", C_FLUSH);
    clr_in();
    // load-use and i-miss are ignored while draining
    hz.ID_EX_MemRead = 1'b1; hz.ID_EX_Rd = 4'd3;
    hz.IF_ID_uses_Rs = 1'b1; hz.IF_ID_Rs = 4'd3; hz.i_mem_busy = 1'b1;
    step("halt_T1", C_FLUSH);
    step("halt_T2", C_FLUSH);
    step("halt_T3", C_FLUSH);
    step("halt_T4", C_HALTED);
    hz.branch_taken = 1'b1;
    step("halt_stay", C_HALTED);
    chk("halt_stall", hz.stall_cycles, 16'd1);
    chk("halt_flush", hz.flush_count, 16'd0);

    // ---- HALT drain with one d_mem_busy cycle at T+2 -> halted at T+5
    do_reset("rst_halt_dm");
    hz.IF_ID_halt = 1'b1;
    step("hdm_T", C_FLUSH);
    clr_in();
    step("hdm_T1", C_FLUSH);
    hz.d_mem_busy = 1'b1;
    step("hdm_T2", C_FREEZE);
    hz.d_mem_busy = 1'b0;
    step("hdm_T3", C_FLUSH);
    step("hdm_T4", C_FLUSH);
    step("hdm_T5", C_HALTED);

    // ---- HALT squashed by a branch at T+1
    do_reset("rst_halt_br");
    hz.IF_ID_halt = 1'b1;
    step("hbr_T", C_FLUSH);
    clr_in();
    hz.branch_taken = 1'b1;
    step("hbr_T1", C_REDIR);
    clr_in();
    for (int i = 2; i < 6; i++) step($sformatf("hbr_T%0d", i), C_NORM);
    chk("hbr_flush", hz.flush_count, 16'd1);

    // ---- reset mid-DRAIN while frozen
    do_reset("rst_mid_pre");
    hz.IF_ID_halt = 1'b1;
    step("mid_T", C_FLUSH);
    clr_in();
    step("mid_T1", C_FLUSH);
    rst_n = 1'b0; hz.d_mem_busy = 1'b1;
    step("mid_rst", C_RST);
    rst_n = 1'b1; hz.d_mem_busy = 1'b0;
    chk("mid_stall", hz.stall_cycles, 16'd0);
    for (int i = 0; i < 5; i++) step($sformatf("mid_run%0d", i), C_NORM);

    // ---- stall counter saturation
    do_reset("rst_sat");
    hz.i_mem_busy = 1'b1;
    step("imiss", C_FLUSH);
    repeat (65539) @(posedge clk);
    #1;
    chk("sat_stall", hz.stall_cycles, 16'hFFFF);
    step("imiss_sat", C_FLUSH);
    chk("sat_hold", hz.stall_cycles, 16'hFFFF);
    clr_in();

    chk("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
